// File: rtl/usb_fs_rx_pkt_decode_pkg.sv
// Shared constants and types for the USB full-speed receive packet decoder.
// Covers PID encodings, PID type codes, CRC polynomials/residuals and FSM state.
package usb_fs_rx_pkt_decode_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;

  // Type is carried in the two low PID bits.
  localparam logic [1:0] PID_TYPE_SPECIAL   = 2'b00;
  localparam logic [1:0] PID_TYPE_TOKEN     = 2'b01;
  localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;
  localparam logic [1:0] PID_TYPE_DATA      = 2'b11;

  localparam logic [4:0]  CRC5_POLY      = 5'b00101;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_RESIDUAL = 16'b1000000000001101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PID  = 2'd1,
    S_BODY = 2'd2
  } state_e;

endpackage

// File: rtl/usb_fs_crc_byte.sv
// Combinational one-byte step of the USB CRC5 and CRC16 registers.
// Bits are consumed LSB first, matching wire order.
module usb_fs_crc_byte
  import usb_fs_rx_pkt_decode_pkg::*;
(
  input  logic [7:0]  data_i,
  input  logic [4:0]  crc5_i,
  input  logic [15:0] crc16_i,
  output logic [4:0]  crc5_o,
  output logic [15:0] crc16_o
);

  logic [4:0]  c5;
  logic [15:0] c16;

  always_comb begin
    c5  = crc5_i;
    c16 = crc16_i;
    for (int i = 0; i < 8; i++) begin
      c5  = {c5[3:0], 1'b0} ^ ({5{data_i[i] ^ c5[4]}} & CRC5_POLY);
      c16 = {c16[14:0], 1'b0} ^ ({16{data_i[i] ^ c16[15]}} & CRC16_POLY);
    end
    crc5_o  = c5;
    crc16_o = c16;
  end

endmodule

// File: rtl/usb_fs_rx_pkt_decode.sv
// Packet-level decoder behind the USB FS bit receiver: checks PID, length and CRC,
// extracts token fields and forwards data bytes to the protocol engines.
module usb_fs_rx_pkt_decode
  import usb_fs_rx_pkt_decode_pkg::*;
#(
  parameter int unsigned MAX_PKT_SIZE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_pkt_start,
  input  logic        in_byte_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_pkt_end,
  input  logic        in_error,
  output logic        rx_pkt_start,
  output logic        rx_pkt_end,
  output logic        rx_pkt_valid,
  output logic [3:0]  rx_pid,
  output logic [6:0]  rx_addr,
  output logic [3:0]  rx_endp,
  output logic [10:0] rx_frame_num,
  output logic        rx_data_put,
  output logic [7:0]  rx_data
);

  localparam int unsigned CNT_MAX = MAX_PKT_SIZE + 3;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        crc5_q, crc5_d, crc5_c;
  logic [15:0]       crc16_q, crc16_d, crc16_c;
  logic              pid_err_q, pid_err_d;
  logic              line_err_q, line_err_d;
  logic [3:0]        pid_q, pid_d;
  logic [6:0]        addr_q;
  logic [3:0]        endp_q;
  logic [10:0]       frame_q;
  logic              start_q, end_q, valid_q, put_q;
  logic [7:0]        data_q;
  logic              active, pid_byte, body_byte, pid_seen;
  logic              len_ok, crc_ok, valid_c;

  usb_fs_crc_byte u_crc (
    .data_i  (in_byte),
    .crc5_i  (crc5_q),
    .crc16_i (crc16_q),
    .crc5_o  (crc5_c),
    .crc16_o (crc16_c)
  );

  // Post-update view so a byte coinciding with EOP joins the end evaluation.
  always_comb begin
    active     = (state_q != S_IDLE);
    pid_byte   = in_byte_valid && (state_q == S_PID);
    body_byte  = in_byte_valid && (state_q == S_BODY);
    pid_seen   = (state_q == S_BODY) || pid_byte;
    pid_d      = pid_byte ? in_byte[3:0] : pid_q;
    pid_err_d  = pid_byte ? (in_byte[7:4] != ~in_byte[3:0]) : pid_err_q;
    line_err_d = line_err_q || (active && in_error);
    cnt_d      = (body_byte && (cnt_q != CNT_W'(CNT_MAX))) ? cnt_q + CNT_W'(1) : cnt_q;
    crc5_d     = body_byte ? crc5_c  : crc5_q;
    crc16_d    = body_byte ? crc16_c : crc16_q;
    len_ok     = 1'b0;
    crc_ok     = 1'b0;
    case (pid_d[1:0])
      PID_TYPE_TOKEN: begin
        len_ok = (cnt_d == CNT_W'(2));
        crc_ok = (crc5_d == CRC5_RESIDUAL);
      end
      PID_TYPE_DATA: begin
        len_ok = (cnt_d >= CNT_W'(2)) && (cnt_d <= CNT_W'(MAX_PKT_SIZE + 2));
        crc_ok = (crc16_d == CRC16_RESIDUAL);
      end
      default: begin
        len_ok = (cnt_d == CNT_W'(0));
        crc_ok = 1'b1;
      end
    endcase
    valid_c = pid_seen && !pid_err_d && !line_err_d && len_ok && crc_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      crc5_q     <= '0;
      crc16_q    <= '0;
      pid_err_q  <= 1'b0;
      line_err_q <= 1'b0;
      pid_q      <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      frame_q    <= '0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      valid_q    <= 1'b0;
      put_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      start_q <= in_pkt_start;
      end_q   <= 1'b0;
      valid_q <= 1'b0;
      put_q   <= 1'b0;
      if (in_pkt_start) begin
        state_q    <= S_PID;
        cnt_q      <= '0;
        crc5_q     <= '1;
        crc16_q    <= '1;
        pid_err_q  <= 1'b0;
        line_err_q <= 1'b0;
      end else if (active) begin
        cnt_q      <= cnt_d;
        crc5_q     <= crc5_d;
        crc16_q    <= crc16_d;
        pid_err_q  <= pid_err_d;
        line_err_q <= line_err_d;
        pid_q      <= pid_d;
        if (pid_byte) state_q <= S_BODY;
        if (body_byte) begin
          if (pid_d[1:0] == PID_TYPE_DATA) begin
            put_q  <= 1'b1;
            data_q <= in_byte;
          end
          if (pid_d[1:0] == PID_TYPE_TOKEN) begin
            if (cnt_q == CNT_W'(0)) begin
              addr_q    <= in_byte[6:0];
              endp_q[0] <= in_byte[7];
            end
            if (cnt_q == CNT_W'(1)) endp_q[3:1] <= in_byte[2:0];
          end
          if (pid_d == PID_SOF) begin
            if (cnt_q == CNT_W'(0)) frame_q[7:0]  <= in_byte;
            if (cnt_q == CNT_W'(1)) frame_q[10:8] <= in_byte[2:0];
          end
        end
        if (in_pkt_end) begin
          state_q <= S_IDLE;
          end_q   <= 1'b1;
          valid_q <= valid_c;
        end
      end
    end
  end

  assign rx_pkt_start = start_q;
  assign rx_pkt_end   = end_q;
  assign rx_pkt_valid = valid_q;
  assign rx_pid       = pid_q;
  assign rx_addr      = addr_q;
  assign rx_endp      = endp_q;
  assign rx_frame_num = frame_q;
  assign rx_data_put  = put_q;
  assign rx_data      = data_q;

endmodule

// File: tb/tb_usb_fs_rx_pkt_decode.sv
// Scoreboard bench for usb_fs_rx_pkt_decode: directed spec packets plus random
// packets judged by a field-level reference model.
module tb_usb_fs_rx_pkt_decode;

  localparam int unsigned MAX = 8;
  localparam logic [1:0] EV_START = 2'd0;
  localparam logic [1:0] EV_PUT   = 2'd1;
  localparam logic [1:0] EV_END   = 2'd2;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic        valid;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_pkt_start = 1'b0, in_byte_valid = 1'b0, in_pkt_end = 1'b0, in_error = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_data_put;
  logic [3:0]  rx_pid, rx_endp;
  logic [6:0]  rx_addr;
  logic [10:0] rx_frame_num;
  logic [7:0]  rx_data;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  // Reference state for fields that persist across packets.
  logic [3:0]  m_pid = '0;
  logic [6:0]  m_addr = '0;
  logic [3:0]  m_endp = '0;
  logic [10:0] m_frame = '0;

  usb_fs_rx_pkt_decode #(.MAX_PKT_SIZE(MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_pkt_start (in_pkt_start),
    .in_byte_valid(in_byte_valid),
    .in_byte      (in_byte),
    .in_pkt_end   (in_pkt_end),
    .in_error     (in_error),
    .rx_pkt_start (rx_pkt_start),
    .rx_pkt_end   (rx_pkt_end),
    .rx_pkt_valid (rx_pkt_valid),
    .rx_pid       (rx_pid),
    .rx_addr      (rx_addr),
    .rx_endp      (rx_endp),
    .rx_frame_num (rx_frame_num),
    .rx_data_put  (rx_data_put),
    .rx_data      (rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC generators, bit-serial polynomial division with all-ones preset.
  function automatic logic [4:0] crc5_of(input logic [10:0] d);
    logic [4:0] c;
    logic fb;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'b00101;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_of(input bq_t b, input int first, input int last);
    logic [15:0] c;
    logic fb;
    logic [7:0] v;
    c = 16'hffff;
    for (int j = first; j <= last; j++) begin
      v = b[j];
      for (int i = 0; i < 8; i++) begin
        fb = v[i] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  function automatic void mk_token(input logic [3:0] pid, input logic [6:0] a,
                                   input logic [3:0] ep, output bq_t b);
    logic [15:0] w;
    logic [4:0] c;
    w[10:0] = {ep, a};
    c = crc5_of(w[10:0]);
    for (int i = 0; i < 5; i++) w[11+i] = ~c[4-i];
    b = '{{~pid, pid}, w[7:0], w[15:8]};
  endfunction

  function automatic void mk_data(input logic [3:0] pid, input int len, output bq_t b);
    logic [15:0] c, f;
    b = '{{~pid, pid}};
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    c = crc16_of(b, 1, len);
    for (int k = 0; k < 16; k++) f[k] = ~c[15-k];
    b.push_back(f[7:0]);
    b.push_back(f[15:8]);
  endfunction

  // Validity judged from packet fields: transmitted CRC field vs recomputed CRC.
  function automatic bit model_valid(input bq_t b, input bit err);
    int n;
    logic [3:0] pid;
    logic [7:0] b0;
    logic [15:0] w, c;
    logic [4:0] c5;
    if (b.size() == 0) return 1'b0;
    b0  = b[0];
    pid = b0[3:0];
    if (b0[7:4] != ~pid) return 1'b0;
    if (err) return 1'b0;
    n = b.size() - 1;
    case (pid[1:0])
      2'b01: begin
        if (n != 2) return 1'b0;
        w  = {b[2], b[1]};
        c5 = crc5_of(w[10:0]);
        for (int i = 0; i < 5; i++) if (w[11+i] != ~c5[4-i]) return 1'b0;
        return 1'b1;
      end
      2'b11: begin
        if (n < 2 || n > int'(MAX) + 2) return 1'b0;
        c = crc16_of(b, 1, n - 2);
        w = {b[n], b[n-1]};
        for (int k = 0; k < 16; k++) if (w[k] != ~c[15-k]) return 1'b0;
        return 1'b1;
      end
      default: return n == 0;
    endcase
  endfunction

  function automatic void upd_held(input bq_t b);
    logic [7:0] b0, b1, b2;
    if (b.size() == 0) return;
    b0 = b[0];
    m_pid = b0[3:0];
    if (b.size() > 1) b1 = b[1]; else b1 = 8'h00;
    if (b.size() > 2) b2 = b[2]; else b2 = 8'h00;
    if (b0[1:0] == 2'b01) begin
      if (b.size() > 1) begin m_addr = b1[6:0]; m_endp[0] = b1[7]; end
      if (b.size() > 2) m_endp[3:1] = b2[2:0];
    end
    if (b0[3:0] == 4'b0101) begin
      if (b.size() > 1) m_frame[7:0] = b1;
      if (b.size() > 2) m_frame[10:8] = b2[2:0];
    end
  endfunction

  function automatic void push(input logic [1:0] k, input logic [7:0] d, input logic v);
    exp_t e;
    e.kind = k; e.data = d; e.valid = v;
    e.pid = m_pid; e.addr = m_addr; e.endp = m_endp; e.frame = m_frame;
    sb.push_back(e);
  endfunction

  function automatic void finish_pkt(input bq_t b, input bit err, input int force_v);
    bit v;
    upd_held(b);
    v = (force_v >= 0) ? force_v[0] : model_valid(b, err);
    push(EV_END, 8'h00, v);
  endfunction

  // Monitor: every DUT output event must match the head of the scoreboard.
  task automatic take(input logic [1:0] k, input logic [7:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_event: got kind %0d, expected none", k);
      return;
    end
    e = sb.pop_front();
    check("event_kind", 32'(k), 32'(e.kind));
    if (k != e.kind) return;
    if (k == EV_PUT) check("rx_data", 32'(d), 32'(e.data));
    if (k == EV_END) begin
      check("rx_pkt_valid", 32'(rx_pkt_valid), 32'(e.valid));
      check("rx_pid", 32'(rx_pid), 32'(e.pid));
      check("rx_addr", 32'(rx_addr), 32'(e.addr));
      check("rx_endp", 32'(rx_endp), 32'(e.endp));
      check("rx_frame_num", 32'(rx_frame_num), 32'(e.frame));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_pkt_start) take(EV_START, 8'h00);
      if (rx_data_put)  take(EV_PUT, rx_data);
      if (rx_pkt_end)   take(EV_END, 8'h00);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input bq_t b, input int err_at, input bit coincide,
                          input int force_v, input bit do_end);
    bit ended, err;
    logic [7:0] b0;
    ended = 1'b0;
    err   = 1'b0;
    b0    = (b.size() > 0) ? b[0] : 8'h00;
    in_pkt_start = 1'b1;
    push(EV_START, 8'h00, 1'b0);
    cyc();
    in_pkt_start = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      if (i == err_at) begin
        in_error = 1'b1; err = 1'b1;
        cyc();
        in_error = 1'b0;
      end
      in_byte_valid = 1'b1;
      in_byte = b[i];
      if (i > 0 && b0[1:0] == 2'b11) push(EV_PUT, b[i], 1'b0);
      if (i == b.size() - 1 && coincide && do_end) begin
        in_pkt_end = 1'b1; ended = 1'b1;
        finish_pkt(b, err, force_v);
      end
      cyc();
      in_byte_valid = 1'b0;
      in_pkt_end = 1'b0;
      in_byte = 8'($urandom);
    end
    if (do_end && !ended) begin
      repeat ($urandom_range(0, 2)) cyc();
      in_pkt_end = 1'b1;
      finish_pkt(b, err, force_v);
      cyc();
      in_pkt_end = 1'b0;
    end
    if (!do_end) upd_held(b);
  endtask

  // Strobes in IDLE must be ignored.
  task automatic idle_noise();
    repeat ($urandom_range(1, 4)) begin
      in_byte_valid = 1'($urandom);
      in_error      = 1'($urandom);
      in_pkt_end    = 1'($urandom);
      in_byte       = 8'($urandom);
      cyc();
    end
    in_byte_valid = 1'b0; in_error = 1'b0; in_pkt_end = 1'b0;
    repeat (2) cyc();
  endtask

  logic [3:0] tok_pids[4] = '{4'h1, 4'h9, 4'h5, 4'hD};
  logic [3:0] dat_pids[4] = '{4'h3, 4'hB, 4'h7, 4'hF};
  logic [3:0] hs_pids[4]  = '{4'h2, 4'hA, 4'hE, 4'h6};

  initial begin
    bq_t b;
    int err_at, idx;
    bit do_end;

    repeat (3) cyc();
    check("reset_rx_pkt_start", 32'(rx_pkt_start), 32'h0);
    check("reset_rx_pkt_end", 32'(rx_pkt_end), 32'h0);
    check("reset_rx_pkt_valid", 32'(rx_pkt_valid), 32'h0);
    check("reset_rx_data_put", 32'(rx_data_put), 32'h0);
    check("reset_fields", 32'({rx_pid, rx_addr, rx_endp, rx_frame_num, rx_data}), 32'h0);
    reset = 1'b0;
    repeat (2) cyc();

    b = '{8'h2D, 8'h00, 8'h10};          send_pkt(b, -1, 1'b0, 1, 1'b1); idle_noise();
    b = '{8'hC3, 8'h00, 8'h00};          send_pkt(b, -1, 1'b1, 1, 1'b1); idle_noise();
    b = '{8'h2D, 8'h00, 8'h11};          send_pkt(b, -1, 1'b0, 0, 1'b1); idle_noise();
    b = '{8'hD2};                        send_pkt(b, -1, 1'b1, 1, 1'b1); idle_noise();
    b = '{8'h2E};                        send_pkt(b, -1, 1'b0, 0, 1'b1); idle_noise();
    mk_data(4'hB, int'(MAX) + 1, b);     send_pkt(b, -1, 1'b0, 0, 1'b1); idle_noise();
    mk_data(4'hB, int'(MAX), b);         send_pkt(b, -1, 1'b1, 1, 1'b1); idle_noise();
    mk_data(4'h3, 4, b);                 send_pkt(b, 3, 1'b0, 0, 1'b1); idle_noise();
    b = '{8'h2D, 8'h00, 8'h10};          send_pkt(b, -1, 1'b1, 1, 1'b1); idle_noise();
    b.delete();                          send_pkt(b, -1, 1'b0, 0, 1'b1); idle_noise();
    mk_token(4'h5, 7'h2A, 4'h6, b);      send_pkt(b, -1, 1'b0, 1, 1'b1); idle_noise();

    // Reset in the middle of a data packet: no end pulse, state cleared.
    in_pkt_start = 1'b1; push(EV_START, 8'h00, 1'b0); cyc(); in_pkt_start = 1'b0;
    in_byte_valid = 1'b1; in_byte = 8'hC3; cyc();
    in_byte = 8'h55; push(EV_PUT, 8'h55, 1'b0); cyc();
    in_byte_valid = 1'b0; cyc(); cyc();
    reset = 1'b1;
    m_pid = '0; m_addr = '0; m_endp = '0; m_frame = '0;
    cyc();
    check("midreset_rx_pkt_end", 32'(rx_pkt_end), 32'h0);
    check("midreset_rx_pid", 32'(rx_pid), 32'h0);
    check("midreset_rx_frame_num", 32'(rx_frame_num), 32'h0);
    reset = 1'b0; cyc();
    b = '{8'h2D, 8'h00, 8'h10};          send_pkt(b, -1, 1'b0, 1, 1'b1); idle_noise();

    for (int t = 0; t < 200; t++) begin
      b.delete();
      case ($urandom_range(0, 3))
        0: mk_token(tok_pids[$urandom_range(0, 3)], 7'($urandom), 4'($urandom), b);
        1: mk_data(dat_pids[$urandom_range(0, 3)], $urandom_range(0, MAX + 1), b);
        2: begin b.push_back({~hs_pids[$urandom_range(0, 3)], 4'h0}); b[0][3:0] = ~b[0][7:4]; end
        default: repeat ($urandom_range(1, 4)) b.push_back(8'($urandom));
      endcase
      if ($urandom_range(0, 4) == 0 && b.size() > 1) begin
        idx = $urandom_range(1, b.size() - 1);
        b[idx] = b[idx] ^ 8'(1 << $urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) b.push_back(8'($urandom));
      if ($urandom_range(0, 9) == 0 && b.size() > 1) void'(b.pop_back());
      err_at = ($urandom_range(0, 9) == 0 && b.size() > 1) ? $urandom_range(1, b.size() - 1) : -1;
      do_end = ($urandom_range(0, 19) != 0);
      send_pkt(b, err_at, 1'($urandom), -1, do_end);
      if (do_end) idle_noise();
    end
    b = '{8'h2D, 8'h00, 8'h10};          send_pkt(b, -1, 1'b0, 1, 1'b1);

    repeat (5) cyc();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_fs_rx_pkt_decode.md
USB_FS_RX_PKT_DECODE -- requirements
Module: usb_fs_rx_pkt_decode

Interface
REQ-001 SHALL have parameter MAX_PKT_SIZE, default 64, the maximum data payload in bytes excluding PID and CRC16.
REQ-002 SHALL have port clk  in  1  sole clock; every output is registered on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_pkt_start  in  1  one-cycle strobe from the bit-level receiver at SYNC end.
REQ-005 SHALL have port in_byte_valid  in  1  strobe qualifying in_byte.
REQ-006 SHALL have port in_byte  in  8  de-stuffed, NRZI-decoded byte; LSB was received first.
REQ-007 SHALL have port in_pkt_end  in  1  one-cycle EOP strobe.
REQ-008 SHALL have port in_error  in  1  bit-stuff or line error strobe within the current packet.
REQ-009 SHALL have outputs rx_pkt_start 1, rx_pkt_end 1, rx_pkt_valid 1, rx_pid 4, rx_addr 7, rx_endp 4, rx_frame_num 11, rx_data_put 1, rx_data 8, all out, feeding the OUT/IN protocol engines.

Function
REQ-010 SHALL run an FSM with states IDLE, PID, BODY: IDLE->PID on in_pkt_start; PID->BODY on the first in_byte_valid; PID/BODY->IDLE on in_pkt_end.
REQ-011 SHALL pulse rx_pkt_start for one cycle, the cycle after in_pkt_start.
REQ-012 On in_pkt_start in PID or BODY, SHALL abort the current packet without an rx_pkt_end pulse and restart in PID.
REQ-013 SHALL latch rx_pid=in_byte[3:0] on the PID byte and flag a PID error when in_byte[7:4] != ~in_byte[3:0].
REQ-014 SHALL count bytes after the PID with a counter that saturates at MAX_PKT_SIZE+3.
REQ-015 SHALL run CRC5 (poly x^5+x^2+1) and CRC16 (poly x^16+x^15+x^2+1) over all post-PID bytes, LSB first, with both registers initialised to all ones at PID.
REQ-016 Token check SHALL pass when the final CRC5 residual is 5'b01100.
REQ-017 Data check SHALL pass when the final CRC16 residual is 16'b1000000000001101.
REQ-018 For a token PID (rx_pid[1:0]=01), SHALL latch rx_addr=byte1[6:0] and rx_endp={byte2[2:0],byte1[7]}.
REQ-019 For SOF (rx_pid=0101), SHALL latch rx_frame_num={byte2[2:0],byte1}.
REQ-020 For a data PID (rx_pid[1:0]=11), SHALL pulse rx_data_put with rx_data=in_byte one cycle after each post-PID in_byte_valid, CRC bytes included; no puts SHALL occur for other PID types.
REQ-021 SHALL pulse rx_pkt_end one cycle after in_pkt_end, with rx_pkt_valid valid in that cycle only.
REQ-022 rx_pkt_valid SHALL be 1 only when all of the following hold:
- no PID error;
- no in_error since PID;
- length rule met: token exactly 2 post-PID bytes, handshake/special 0 bytes, data 2..MAX_PKT_SIZE+2 bytes;
- CRC check for the type passes.
REQ-023 When in_byte_valid and in_pkt_end coincide, SHALL process the byte first and include it in the end evaluation.
REQ-024 in_pkt_end with no PID byte received SHALL produce rx_pkt_end with rx_pkt_valid=0.
REQ-025 SHALL ignore in_byte_valid, in_pkt_end and in_error in IDLE.
REQ-026 rx_pid, rx_addr, rx_endp and rx_frame_num SHALL hold their values until overwritten by a later packet.

Reset
REQ-027 On reset, SHALL force the FSM to IDLE and clear every output, CRC register, counter and error flag to 0 (CRC registers reinitialise to all ones at PID).
REQ-028 Reset mid-packet SHALL emit no rx_pkt_end; the first packet after release SHALL decode normally.

Structure
REQ-029 The shared package SHALL hold the PID encodings, PID type codes, CRC polynomials and residual constants, and the FSM state type.
REQ-030 One sub-module, usb_fs_crc_byte, SHALL hold the combinational 8-bit-per-step CRC5/CRC16 update; all other logic stays inline.

Verification
REQ-031 SETUP bytes 2D 00 10 -> rx_pkt_valid=1, rx_pid=D, rx_addr=0, rx_endp=0, no rx_data_put.
REQ-032 DATA0 zero-length bytes C3 00 00 -> two rx_data_put pulses (00, 00), then rx_pkt_end with rx_pkt_valid=1.
REQ-033 Corrupted token 2D 00 11 -> rx_pkt_valid=0; ACK D2 -> rx_pkt_valid=1, rx_pid=2.
REQ-034 PID byte 2E -> rx_pkt_valid=0.
REQ-035 DATA1 of MAX_PKT_SIZE+1 payload bytes with good CRC -> rx_pkt_valid=0.
REQ-036 in_error during a data payload, or reset asserted mid-packet -> rx_pkt_valid=0, or no rx_pkt_end respectively; the following SETUP 2D 00 10 decodes valid.
